// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller, its enable decoder and benches.
// Holds the FSM state type, command encodings, error codes and unit-index mapping.
package fpu_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_SRST
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_FMA = 2'd3
    } fpu_op_t;

    typedef enum logic [1:0] {
        FMT_SINGLE  = 2'd0,
        FMT_BINARY  = 2'd1,
        FMT_DECIMAL = 2'd2,
        FMT_ILLEGAL = 2'd3
    } fpu_fmt_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_FORMAT  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_UNIT    = 2'd3;

    localparam int NUM_UNITS = 12;

    // Units are laid out op-major, format-minor, counting down from bit 11.
    function automatic logic [3:0] expected_unit(input logic [1:0] op, input logic [1:0] fmt);
        logic [3:0] lin;
        lin = 4'(op) * 4'd3 + 4'(fmt);
        return 4'd11 - lin;
    endfunction

endpackage

// File: rtl/fpu_timeout_cnt.sv
// 16-bit wait-cycle counter: load clears, enable counts, expire flags the last allowed cycle.
module fpu_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Counter starts at 0 in the first wait cycle, so LIMIT-1 marks the LIMIT-th cycle.
    assign expire = en && (count_q == 16'(LIMIT - 1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller: accepts one FPU command, rings the scalar or SIMD doorbell,
// waits for the matching unit to finish (or times out) and supports soft reset.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SRST_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_operation,
    input  logic [1:0]  cmd_format,
    input  logic        cmd_simd,
    input  logic        soft_rst_req,
    input  logic [11:0] unit_done,
    output logic        fpu_en,
    output logic [1:0]  fpu_operation,
    output logic [1:0]  fpu_format,
    output logic        fpu_doorbell_w,
    output logic        simd_doorbell,
    output logic        fpu_rst_w,
    output logic        busy,
    output logic        done_pulse,
    output logic [1:0]  err_code
);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  fmt_q, fmt_d;
    logic        simd_q, simd_d;
    logic [3:0]  exp_unit_q, exp_unit_d;
    logic [1:0]  err_q, err_d;
    logic [3:0]  srst_cnt_q, srst_cnt_d;
    logic        fpu_en_q, fpu_en_d;
    logic        fpu_db_q, fpu_db_d;
    logic        simd_db_q, simd_db_d;
    logic        fpu_rst_q, fpu_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        accept;
    logic        tmo_load;
    logic        tmo_en;
    logic        tmo_expire;

    assign cmd_ready = (state_q == ST_IDLE) && rst_n && !soft_rst_req;
    assign accept    = cmd_valid && cmd_ready;
    assign tmo_load  = (state_q == ST_ISSUE);
    assign tmo_en    = (state_q == ST_WAIT);

    fpu_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmo_load),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        fmt_d      = fmt_q;
        simd_d     = simd_q;
        exp_unit_d = exp_unit_q;
        err_d      = err_q;
        srst_cnt_d = srst_cnt_q;

        if (soft_rst_req) begin
            state_d    = ST_SRST;
            srst_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        err_d = ERR_OK;
                        if (cmd_format == FMT_ILLEGAL) begin
                            state_d = ST_DONE;
                            err_d   = ERR_FORMAT;
                        end else begin
                            state_d    = ST_ISSUE;
                            op_d       = cmd_operation;
                            fmt_d      = cmd_format;
                            simd_d     = cmd_simd;
                            exp_unit_d = expected_unit(cmd_operation, cmd_format);
                        end
                    end
                end
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT: begin
                    // Completion beats timeout when both land in the same cycle.
                    if (unit_done[exp_unit_q]) begin
                        state_d = ST_DONE;
                        err_d   = ERR_OK;
                    end else if (|unit_done) begin
                        state_d = ST_DONE;
                        err_d   = ERR_UNIT;
                    end else if (tmo_expire) begin
                        state_d = ST_DONE;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_SRST: begin
                    if (srst_cnt_q == 4'(SRST_CYCLES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        srst_cnt_d = srst_cnt_q + 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        fpu_en_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        fpu_db_d  = (state_d == ST_ISSUE) && !simd_d;
        simd_db_d = (state_d == ST_ISSUE) && simd_d;
        fpu_rst_d = (state_d == ST_SRST);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            fmt_q      <= '0;
            simd_q     <= 1'b0;
            exp_unit_q <= '0;
            err_q      <= ERR_OK;
            srst_cnt_q <= '0;
            fpu_en_q   <= 1'b0;
            fpu_db_q   <= 1'b0;
            simd_db_q  <= 1'b0;
            fpu_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            fmt_q      <= fmt_d;
            simd_q     <= simd_d;
            exp_unit_q <= exp_unit_d;
            err_q      <= err_d;
            srst_cnt_q <= srst_cnt_d;
            fpu_en_q   <= fpu_en_d;
            fpu_db_q   <= fpu_db_d;
            simd_db_q  <= simd_db_d;
            fpu_rst_q  <= fpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fpu_en         = fpu_en_q;
    assign fpu_operation  = op_q;
    assign fpu_format     = fmt_q;
    assign fpu_doorbell_w = fpu_db_q;
    assign simd_doorbell  = simd_db_q;
    assign fpu_rst_w      = fpu_rst_q;
    assign busy           = busy_q;
    assign done_pulse     = done_q;
    assign err_code       = err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized self-checking bench for fpu_issue_ctrl against a per-transaction timeline model.
module tb_fpu_issue_ctrl;

    localparam int TMO  = 255;
    localparam int SRST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_operation;
    logic [1:0]  cmd_format;
    logic        cmd_simd;
    logic        soft_rst_req;
    logic [11:0] unit_done;
    logic        fpu_en;
    logic [1:0]  fpu_operation;
    logic [1:0]  fpu_format;
    logic        fpu_doorbell_w;
    logic        simd_doorbell;
    logic        fpu_rst_w;
    logic        busy;
    logic        done_pulse;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    // Model state that persists between transactions.
    int exp_err = 0;
    int exp_op  = 0;
    int exp_fmt = 0;

    fpu_issue_ctrl #(
        .TIMEOUT_CYCLES (TMO),
        .SRST_CYCLES    (SRST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_operation  (cmd_operation),
        .cmd_format     (cmd_format),
        .cmd_simd       (cmd_simd),
        .soft_rst_req   (soft_rst_req),
        .unit_done      (unit_done),
        .fpu_en         (fpu_en),
        .fpu_operation  (fpu_operation),
        .fpu_format     (fpu_format),
        .fpu_doorbell_w (fpu_doorbell_w),
        .simd_doorbell  (simd_doorbell),
        .fpu_rst_w      (fpu_rst_w),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_outs(input string tag, input int en, input int fdb, input int sdb,
                               input int rstw, input int bsy, input int dn);
        check_eq({tag, ".fpu_en"}, int'(fpu_en), en);
        check_eq({tag, ".fpu_db"}, int'(fpu_doorbell_w), fdb);
        check_eq({tag, ".simd_db"}, int'(simd_doorbell), sdb);
        check_eq({tag, ".fpu_rst_w"}, int'(fpu_rst_w), rstw);
        check_eq({tag, ".busy"}, int'(busy), bsy);
        check_eq({tag, ".done"}, int'(done_pulse), dn);
        check_eq({tag, ".err"}, int'(err_code), exp_err);
        check_eq({tag, ".op"}, int'(fpu_operation), exp_op);
        check_eq({tag, ".fmt"}, int'(fpu_format), exp_fmt);
    endtask

    task automatic expect_idle(input string tag);
        expect_outs(tag, 0, 0, 0, 0, 0, 0);
        check_eq({tag, ".ready"}, int'(cmd_ready), 1);
    endtask

    // Soft reset from the current cycle; request held for 'hold' cycles in total.
    task automatic do_srst(input int hold);
        soft_rst_req = 1'b1;
        #1;
        check_eq("srst.ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        for (int i = 1; i < hold; i++) begin
            expect_outs("srst.restart", 0, 0, 0, 1, 1, 0);
            @(negedge clk);
        end
        soft_rst_req = 1'b0;
        for (int i = 0; i < SRST; i++) begin
            expect_outs("srst", 0, 0, 0, 1, 1, 0);
            @(negedge clk);
        end
        expect_idle("srst.idle");
        $display("txn soft_reset hold=%0d", hold);
    endtask

    task automatic do_hard_rst();
        rst_n = 1'b0;
        @(negedge clk);
        exp_err = 0;
        exp_op  = 0;
        exp_fmt = 0;
        expect_outs("hrst", 0, 0, 0, 0, 0, 0);
        check_eq("hrst.ready", int'(cmd_ready), 0);
        rst_n = 1'b1;
        #1;
        check_eq("hrst.ready_after", int'(cmd_ready), 1);
        @(negedge clk);
        expect_idle("hrst.idle");
        $display("txn hard_reset");
    endtask

    // One command: unit_done=vec presented in wait cycle 'delay'; abort at wait cycle abort_at.
    task automatic run_cmd(input int op, input int fmt, input int simd, input int delay,
                           input logic [11:0] vec, input int abort_at, input int hard,
                           input int hold);
        int unit;
        cmd_valid     = 1'b1;
        cmd_operation = 2'(op);
        cmd_format    = 2'(fmt);
        cmd_simd      = simd[0];
        #1;
        check_eq("accept.ready", int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid     = 1'b0;
        cmd_operation = 2'($urandom_range(0, 3));
        cmd_format    = 2'($urandom_range(0, 3));
        exp_err = 0;
        if (fmt == 3) begin
            exp_err = 1;
            expect_outs("fmt3.done", 0, 0, 0, 0, 1, 1);
            @(negedge clk);
            expect_idle("fmt3.idle");
            $display("txn op=%0d fmt=%0d illegal err=%0d", op, fmt, exp_err);
            return;
        end
        exp_op  = op;
        exp_fmt = fmt;
        expect_outs("issue", 1, (simd == 0) ? 1 : 0, simd, 0, 1, 0);
        @(negedge clk);
        unit = 11 - (3 * op + fmt);
        for (int w = 0; w < TMO; w++) begin
            expect_outs("wait", 1, 0, 0, 0, 1, 0);
            if (w == abort_at) begin
                if (hard != 0) do_hard_rst();
                else do_srst(hold);
                return;
            end
            if (w == delay && vec != 12'h0) begin
                unit_done = vec;
                @(negedge clk);
                unit_done = 12'h0;
                exp_err = vec[unit] ? 0 : 3;
                expect_outs("done", 0, 0, 0, 0, 1, 1);
                @(negedge clk);
                expect_idle("done.idle");
                $display("txn op=%0d fmt=%0d simd=%0d done@%0d vec=%03h err=%0d",
                         op, fmt, simd, w, vec, exp_err);
                return;
            end
            @(negedge clk);
        end
        exp_err = 2;
        expect_outs("tmo.done", 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        expect_idle("tmo.idle");
        $display("txn op=%0d fmt=%0d simd=%0d timeout err=%0d", op, fmt, simd, exp_err);
    endtask

    initial begin
        int op, fmt, simd, delay, unit, kind, abort_at;
        logic [11:0] vec;

        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_operation = 2'd0;
        cmd_format    = 2'd0;
        cmd_simd      = 1'b0;
        soft_rst_req  = 1'b0;
        unit_done     = 12'h0;
        repeat (3) @(negedge clk);
        expect_outs("reset", 0, 0, 0, 0, 0, 0);
        check_eq("reset.ready", int'(cmd_ready), 0);
        rst_n = 1'b1;
        #1;
        check_eq("reset.ready_after", int'(cmd_ready), 1);
        @(negedge clk);
        expect_idle("post_reset");

        run_cmd(2, 1, 0, 2, 12'h010, -1, 0, 1);
        run_cmd(1, 3, 0, 0, 12'h0, -1, 0, 1);
        run_cmd(0, 0, 1, 1000, 12'h0, -1, 0, 1);
        run_cmd(3, 2, 0, 0, 12'h020, -1, 0, 1);
        run_cmd(3, 2, 0, 0, 12'h021, -1, 0, 1);
        run_cmd(2, 1, 0, 1000, 12'h0, 5, 0, 1);
        run_cmd(1, 1, 1, 1000, 12'h0, 3, 1, 1);
        run_cmd(1, 2, 0, TMO - 1, 12'h008, -1, 0, 1);
        run_cmd(0, 1, 1, TMO - 1, 12'h001, -1, 0, 1);
        do_srst(3);
        run_cmd(2, 0, 1, 0, 12'hFFF, 7, 0, 2);

        for (int t = 0; t < 40; t++) begin
            op    = $urandom_range(0, 3);
            fmt   = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            simd  = $urandom_range(0, 1);
            delay = ($urandom_range(0, 9) == 0) ? TMO + 10 : $urandom_range(0, 40);
            unit  = 11 - (3 * op + fmt);
            kind  = $urandom_range(0, 2);
            vec   = 12'h0;
            if (fmt != 3) begin
                vec[unit] = 1'b1;
                if (kind == 1) vec = vec | 12'($urandom);
                if (kind == 2) begin
                    vec = 12'($urandom);
                    vec[unit] = 1'b0;
                    if (vec == 12'h0) vec[(unit + 1) % 12] = 1'b1;
                end
            end
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : -1;
            run_cmd(op, fmt, simd, delay, vec, abort_at, $urandom_range(0, 3) == 0 ? 1 : 0,
                    $urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                expect_idle("gap");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum WAIT cycles before abort (legal range 1..65535).
REQ-002 SHALL have parameter SRST_CYCLES, default 4, meaning number of cycles fpu_rst_w is held during soft reset (legal range 1..15).
REQ-003 SHALL have ports:
  clk  in  1  single clock, all logic rising-edge.
  rst_n  in  1  reset, synchronous, active-low.
  cmd_valid  in  1  command offered.
  cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
  cmd_operation  in  2  0=ADD, 1=SUB, 2=MUL, 3=FMA.
  cmd_format  in  2  0=single, 1=binary, 2=decimal, 3=illegal.
  cmd_simd  in  1  issue on simd_doorbell instead of fpu_doorbell_w.
  soft_rst_req  in  1  soft-reset request pulse.
  unit_done  in  12  per-unit completion, same bit order as the enable-decoder output.
  fpu_en  out  1  issue qualifier to the enable decoder.
  fpu_operation  out  2  registered operation to the enable decoder.
  fpu_format  out  2  registered format to the enable decoder.
  fpu_doorbell_w  out  1  scalar doorbell pulse.
  simd_doorbell  out  1  SIMD doorbell pulse.
  fpu_rst_w  out  1  FPU soft reset to the enable decoder.
  busy  out  1  high in any state except IDLE.
  done_pulse  out  1  one-cycle completion strobe.
  err_code  out  2  0=ok, 1=illegal format, 2=timeout, 3=wrong unit done.

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE, SRST.
REQ-005 cmd_ready SHALL be high only in IDLE and only when soft_rst_req is low.
REQ-006 IDLE: on accept with cmd_format!=3, SHALL register operation, format and simd, and go to ISSUE.
REQ-007 IDLE: on accept with cmd_format==3, SHALL go to DONE with err_code=1 and issue no doorbell.
REQ-008 ISSUE SHALL last exactly 1 cycle with fpu_en=1 and exactly one doorbell high (simd_doorbell if simd, else fpu_doorbell_w), then go to WAIT.
REQ-009 Doorbell SHALL rise the cycle after acceptance (latency 1); fpu_operation/fpu_format SHALL be valid in that cycle and held until the next accept.
REQ-010 Expected unit index SHALL be 11 - (3*operation + format).
REQ-011 WAIT: fpu_en SHALL stay 1 and doorbells SHALL stay 0; timeout counter SHALL increment each cycle starting from 0.
REQ-012 WAIT: if unit_done[expected] is high, SHALL go to DONE with err_code=0, even if other bits are also high.
REQ-013 WAIT: if unit_done is nonzero without the expected bit, SHALL go to DONE with err_code=3.
REQ-014 WAIT: if the counter reaches TIMEOUT_CYCLES with no done, SHALL go to DONE with err_code=2.
REQ-015 When done and timeout coincide in the same cycle, the done result SHALL take priority.
REQ-016 DONE SHALL last 1 cycle with done_pulse=1 and fpu_en=0, then go to IDLE.
REQ-017 err_code SHALL hold its value until the next accept, which clears it to 0.
REQ-018 soft_rst_req high in any state SHALL force SRST on the next edge, aborting any command without a done_pulse; it has priority over all other transitions.
REQ-019 SRST: fpu_rst_w=1 for SRST_CYCLES cycles, fpu_en=0, then go to IDLE; a new soft_rst_req during SRST SHALL restart the count.
REQ-020 All outputs SHALL be registered, or decoded directly from state registers.

Reset
REQ-021 While rst_n=0 at a clock edge: state=IDLE, counters=0, fpu_en=0, doorbells=0, fpu_rst_w=0, done_pulse=0, busy=0, err_code=0, fpu_operation=0, fpu_format=0.
REQ-022 cmd_ready SHALL be 0 in the reset cycle and 1 in the first cycle after rst_n rises.
REQ-023 Reset mid-operation SHALL discard the command silently, with no done_pulse.

Structure
REQ-024 Shared package SHALL hold the state enum, operation/format encodings, err_code constants and the expected-index function, for reuse by the enable decoder and testbench.
REQ-025 One sub-module, fpu_timeout_cnt (load/enable/expire, 16-bit), SHALL be instantiated; everything else stays in a single module.

Verification
REQ-026 Accept MUL/binary (op=2, fmt=1, simd=0); unit_done[4] 3 cycles after the doorbell -> fpu_doorbell_w pulse on cycle+1, done_pulse 1 cycle later, err_code=0.
REQ-027 Accept fmt=3 -> no doorbell, done_pulse on the next cycle, err_code=1.
REQ-028 Accept ADD/single (op=0, fmt=0, simd=1), unit_done held at 0 -> simd_doorbell pulse, done_pulse after 255 WAIT cycles, err_code=2.
REQ-029 Accept FMA/decimal (op=3, fmt=2, expected bit 0), assert unit_done[5] -> err_code=3; assert unit_done=12'h021 instead -> err_code=0.
REQ-030 Assert soft_rst_req mid-WAIT -> fpu_rst_w high 4 cycles, no done_pulse, cmd_ready=1 on the following cycle; also drive rst_n=0 mid-WAIT -> all outputs reach reset values at the next edge.
